scale_ctrl: RTL and testbench

SCALE_CTRL -- requirements
Module: scale_ctrl

---
 rtl/scale_ctrl_pkg.sv | 30 +++
 rtl/scale_ctrl_shift.sv | 38 +++
 rtl/scale_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_scale_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_ctrl_pkg.sv
// Shared types and constants for the scale_ctrl frame scaler.
// Holds the FSM state encoding, the shift codes and the shift-code normaliser.
package scale_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] SH0 = 2'd0;
    localparam logic [1:0] SH1 = 2'd1;
    localparam logic [1:0] SH2 = 2'd2;

    // Code 3 has no shift of its own and behaves exactly like SH2.
    function automatic logic [1:0] norm_code(input logic [1:0] code);
        logic [1:0] res;
        case (code)
            SH0:     res = SH0;
            SH1:     res = SH1;
            default: res = SH2;
        endcase
        return res;
    endfunction

    // True when the two MSBs disagree, i.e. the value does not fit in WL-1 bits.
    function automatic logic top_bits_differ(input logic msb, input logic nmsb);
        return msb ^ nmsb;
    endfunction

endpackage

// File: rtl/scale_ctrl_shift.sv
// scale_shift: combinational complex arithmetic right shift by 0, 1 or 2 bits.
// Real and imaginary parts are shifted independently, sign-extended, truncated.
module scale_shift
    import scale_ctrl_pkg::*;
#(
    parameter int WL = 16
) (
    input  logic [WL-1:0] in_r,
    input  logic [WL-1:0] in_i,
    input  logic [1:0]    code,
    output logic [WL-1:0] out_r,
    output logic [WL-1:0] out_i
);

    logic [1:0] code_s;

    // Select the shifted real/imag values for the normalised code.
    always_comb begin
        code_s = norm_code(code);
        out_r  = in_r;
        out_i  = in_i;
        case (code_s)
            SH0: begin
                out_r = in_r;
                out_i = in_i;
            end
            SH1: begin
                out_r = $unsigned($signed(in_r) >>> 1);
                out_i = $unsigned($signed(in_i) >>> 1);
            end
            default: begin
                out_r = $unsigned($signed(in_r) >>> 2);
                out_i = $unsigned($signed(in_i) >>> 2);
            end
        endcase
    end

endmodule

// File: rtl/scale_ctrl.sv
// scale_ctrl: per-stage block scaler for a radix-4 frame of NPT*STAGES samples.
// Optional macro SCALE_CTRL_GUARD_MON_EN adds the sticky guard_ovf monitor output.
module scale_ctrl
    import scale_ctrl_pkg::*;
#(
    parameter int WL     = 16,
    parameter int NPT    = 64,
    parameter int STAGES = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [2*STAGES-1:0]           cfg_sched,
    input  logic                          in_valid,
    input  logic                          in_sop,
    input  logic [WL-1:0]                 in_r,
    input  logic [WL-1:0]                 in_i,
    output logic                          out_valid,
    output logic                          out_sop,
    output logic [WL-1:0]                 out_r,
    output logic [WL-1:0]                 out_i,
    output logic [$clog2(STAGES+1)-1:0]   stage_idx,
    output logic                          busy,
    output logic                          frame_done
`ifdef SCALE_CTRL_GUARD_MON_EN
    ,
    output logic                          guard_ovf
`endif
);

    localparam int CNT_W = $clog2(NPT);
    localparam int STG_W = $clog2(STAGES+1);
    localparam int SCH_W = 2*STAGES;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NPT-1);
    localparam logic [STG_W-1:0] STG_LAST  = STG_W'(STAGES-1);
    localparam logic [SCH_W-1:0] SCHED_RST = {STAGES{SH2}};

    state_t             state_r;
    logic [CNT_W-1:0]   count_r;
    logic [STG_W-1:0]   stage_r;
    logic [SCH_W-1:0]   sched_r;
    logic               busy_r;
    logic               frame_done_r;
    logic               out_valid_r;
    logic               out_sop_r;
    logic [WL-1:0]      out_r_r;
    logic [WL-1:0]      out_i_r;

    logic               start_s;
    logic               accept_s;
    logic [SCH_W-1:0]   eff_sched_s;
    logic [STG_W-1:0]   eff_stage_s;
    logic [1:0]         code_s;
    logic [WL-1:0]      shr_r_s;
    logic [WL-1:0]      shr_i_s;

    // Decode acceptance and the shift code that applies to the present sample.
    always_comb begin
        start_s     = in_valid & in_sop;
        accept_s    = 1'b0;
        eff_sched_s = sched_r;
        eff_stage_s = stage_r;
        code_s      = SH2;
        if (state_r == RUN) begin
            accept_s = in_valid;
        end else begin
            accept_s = start_s;
        end
        // A write landing with the frame start already governs that frame.
        if ((state_r == IDLE) && cfg_we) begin
            eff_sched_s = cfg_sched;
        end else begin
            eff_sched_s = sched_r;
        end
        if (start_s) begin
            eff_stage_s = '0;
        end else begin
            eff_stage_s = stage_r;
        end
        for (int s = 0; s < STAGES; s++) begin
            if (eff_stage_s == STG_W'(s)) begin
                code_s = eff_sched_s[2*s +: 2];
            end else begin
                code_s = code_s;
            end
        end
    end

    scale_shift #(
        .WL    (WL)
    ) u_shift (
        .in_r  (in_r),
        .in_i  (in_i),
        .code  (code_s),
        .out_r (shr_r_s),
        .out_i (shr_i_s)
    );

    // Frame sequencing FSM: sample/stage counters, schedule latch, busy and frame_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            count_r      <= '0;
            stage_r      <= '0;
            sched_r      <= SCHED_RST;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cfg_we) begin
                        sched_r <= cfg_sched;
                    end
                    if (start_s) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        count_r <= CNT_W'(1);
                        stage_r <= '0;
                    end
                end
                RUN: begin
                    if (start_s) begin
                        count_r <= CNT_W'(1);
                        stage_r <= '0;
                    end else if (in_valid) begin
                        if (count_r == CNT_LAST) begin
                            count_r <= '0;
                            if (stage_r == STG_LAST) begin
                                state_r      <= IDLE;
                                busy_r       <= 1'b0;
                                stage_r      <= '0;
                                frame_done_r <= 1'b1;
                            end else begin
                                stage_r <= stage_r + STG_W'(1);
                            end
                        end else begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    count_r <= '0;
                    stage_r <= '0;
                end
            endcase
        end
    end

    // Output register: one-cycle latency, data held across invalid cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_sop_r   <= 1'b0;
            out_r_r     <= '0;
            out_i_r     <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_sop_r   <= in_sop;
            out_r_r     <= shr_r_s;
            out_i_r     <= shr_i_s;
        end else begin
            out_valid_r <= 1'b0;
            out_sop_r   <= 1'b0;
        end
    end

`ifdef SCALE_CTRL_GUARD_MON_EN
    logic guard_r;
    logic ovf_s;

    // Flag a sample that would need a shift but is passed through unshifted.
    always_comb begin
        if (accept_s && (norm_code(code_s) == SH0)) begin
            ovf_s = top_bits_differ(in_r[WL-1], in_r[WL-2]) |
                    top_bits_differ(in_i[WL-1], in_i[WL-2]);
        end else begin
            ovf_s = 1'b0;
        end
    end

    // Sticky guard flag, restarted by each frame-starting sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            guard_r <= 1'b0;
        end else if (start_s) begin
            guard_r <= ovf_s;
        end else if (ovf_s) begin
            guard_r <= 1'b1;
        end
    end

    assign guard_ovf = guard_r;
`endif

    assign out_valid  = out_valid_r;
    assign out_sop    = out_sop_r;
    assign out_r      = out_r_r;
    assign out_i      = out_i_r;
    assign stage_idx  = stage_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_scale_ctrl.sv
// Self-checking bench for scale_ctrl: directed scenarios plus randomized frames
// checked against a frame-position model; guard checks when SCALE_CTRL_GUARD_MON_EN.
module tb_scale_ctrl;

    localparam int WL     = 16;
    localparam int NPT    = 64;
    localparam int STAGES = 3;
    localparam int FRAME  = NPT*STAGES;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [5:0]  cfg_sched;
    logic        in_valid;
    logic        in_sop;
    logic [15:0] in_r;
    logic [15:0] in_i;
    logic        out_valid;
    logic        out_sop;
    logic [15:0] out_r;
    logic [15:0] out_i;
    logic [1:0]  stage_idx;
    logic        busy;
    logic        frame_done;
`ifdef SCALE_CTRL_GUARD_MON_EN
    logic        guard_ovf;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: position within the frame, not counters.
    bit          busy_m;
    int          pos_m;
    logic [5:0]  sched_m;
    logic [15:0] hold_r_m;
    logic [15:0] hold_i_m;
    bit          guard_m;

    scale_ctrl #(
        .WL         (WL),
        .NPT        (NPT),
        .STAGES     (STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_sched  (cfg_sched),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_r       (in_r),
        .in_i       (in_i),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_r      (out_r),
        .out_i      (out_i),
        .stage_idx  (stage_idx),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef SCALE_CTRL_GUARD_MON_EN
        ,
        .guard_ovf  (guard_ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Floor division by 2^k on the signed value.
    function automatic logic [15:0] ref_scale(input logic [15:0] x, input int k);
        int v;
        int d;
        int q;
        v = int'($signed(x));
        d = 1 << k;
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);
        return 16'(q);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input bit s, input logic [15:0] r, input logic [15:0] im,
                        input bit we, input logic [5:0] sc);
        bit         acc;
        bit         done;
        bit         exp_sop;
        int         stg;
        int         k;
        logic [1:0] c;
        @(negedge clk);
        in_valid  = v;
        in_sop    = s;
        in_r      = r;
        in_i      = im;
        cfg_we    = we;
        cfg_sched = sc;
        if (!busy_m && we) sched_m = sc;
        acc     = v && (s || busy_m);
        done    = 1'b0;
        exp_sop = 1'b0;
        if (acc) begin
            if (s) begin
                pos_m   = 0;
                guard_m = 1'b0;
            end
            stg = pos_m / NPT;
            c   = sched_m[2*stg +: 2];
            k   = (c == 2'd3) ? 2 : int'(c);
            if (k == 0 && (r[15] != r[14] || im[15] != im[14])) guard_m = 1'b1;
            hold_r_m = ref_scale(r, k);
            hold_i_m = ref_scale(im, k);
            exp_sop  = s;
            done     = (pos_m == FRAME-1);
            pos_m++;
            if (done) begin
                busy_m = 1'b0;
                pos_m  = 0;
            end else begin
                busy_m = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(acc));
        chk("out_sop", 32'(out_sop), 32'(exp_sop));
        chk("out_r", 32'(out_r), 32'(hold_r_m));
        chk("out_i", 32'(out_i), 32'(hold_i_m));
        chk("frame_done", 32'(frame_done), 32'(done));
        chk("busy", 32'(busy), 32'(busy_m));
        chk("stage_idx", 32'(stage_idx), busy_m ? 32'(pos_m / NPT) : 32'd0);
`ifdef SCALE_CTRL_GUARD_MON_EN
        chk("guard_ovf", 32'(guard_ovf), 32'(guard_m));
`endif
    endtask

    // Reset with traffic and a config write pending, to show rst wins.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sop    = 1'b1;
        cfg_we    = 1'b1;
        cfg_sched = 6'b000000;
        in_r      = 16'h7FFF;
        in_i      = 16'h8000;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sop", 32'(out_sop), 32'd0);
        chk("rst_out_r", 32'(out_r), 32'd0);
        chk("rst_out_i", 32'(out_i), 32'd0);
        chk("rst_stage_idx", 32'(stage_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef SCALE_CTRL_GUARD_MON_EN
        chk("rst_guard_ovf", 32'(guard_ovf), 32'd0);
`endif
        busy_m   = 1'b0;
        pos_m    = 0;
        sched_m  = 6'b101010;
        hold_r_m = 16'h0000;
        hold_i_m = 16'h0000;
        guard_m  = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        cfg_we   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_sched = 6'b0; in_valid = 1'b0; in_sop = 1'b0;
        in_r = 16'h0; in_i = 16'h0;
        do_reset();

        // Default schedule, constant data: every output is input/4.
        for (int n = 0; n < FRAME; n++) step(1'b1, n == 0, 16'h4000, 16'hC000, 1'b0, 6'b0);
        chk("div4_r_const", 32'(out_r), 32'h1000);
        chk("div4_i_const", 32'(out_i), 32'hF000);
        step(1'b1, 1'b0, 16'h1234, 16'h4321, 1'b0, 6'b0);

        // Per-stage schedule 2/1/0 on the most negative value.
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 6'b00_01_10);
        for (int n = 0; n < FRAME; n++) begin
            step(1'b1, n == 0, 16'h8000, 16'h8000, 1'b0, 6'b0);
            if (n == 0)       chk("sched_stage0", 32'(out_r), 32'hE000);
            if (n == NPT)     chk("sched_stage1", 32'(out_r), 32'hC000);
            if (n == 2*NPT)   chk("sched_stage2", 32'(out_r), 32'h8000);
        end

        // Restart at sample 70, then a full frame after it.
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 6'b101010);
        for (int n = 0; n < 70; n++) step(1'b1, n == 0, 16'($urandom), 16'($urandom), 1'b0, 6'b0);
        for (int n = 0; n < FRAME; n++) step(1'b1, n == 0, 16'($urandom), 16'($urandom), 1'b0, 6'b0);

        // Config write during RUN ignored; write with frame start applies.
        for (int n = 0; n < 50; n++) step(1'b1, n == 0, 16'($urandom), 16'($urandom), 1'b0, 6'b0);
        step(1'b1, 1'b0, 16'h7FFC, 16'h8004, 1'b1, 6'b000000);
        chk("run_we_ignored", 32'(out_r), 32'h1FFF);
        for (int n = 51; n < FRAME; n++) step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 6'b0);
        step(1'b1, 1'b0, 16'h5555, 16'h5555, 1'b0, 6'b0);
        for (int n = 0; n < FRAME; n++) step(1'b1, n == 0, 16'($urandom), 16'($urandom), n == 0, 6'b000000);
        step(1'b1, 1'b1, 16'h7FFF, 16'h8001, 1'b0, 6'b0);
        chk("we_sop_passthru", 32'(out_r), 32'h7FFF);

        // 50% duty input until mid stage 1, then reset.
        for (int n = 0; n < 2*(NPT+20); n++) step(n[0] == 1'b0, n == 0, 16'($urandom), 16'($urandom), 1'b0, 6'b0);
        do_reset();

`ifdef SCALE_CTRL_GUARD_MON_EN
        // Unshifted stage sees a value that overflows WL-1 bits.
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 6'b101000);
        step(1'b1, 1'b1, 16'h0100, 16'h0100, 1'b0, 6'b0);
        step(1'b1, 1'b0, 16'h5000, 16'h0000, 1'b0, 6'b0);
        for (int n = 2; n < FRAME; n++) step(1'b1, 1'b0, 16'h0010, 16'h0010, 1'b0, 6'b0);
        chk("guard_held", 32'(guard_ovf), 32'd1);
        step(1'b1, 1'b1, 16'h0010, 16'h0010, 1'b0, 6'b0);
        chk("guard_cleared", 32'(guard_ovf), 32'd0);
        do_reset();
`endif

        // Randomized frames: random schedule, gaps, stray valids and rare restarts.
        for (int f = 0; f < 5; f++) begin
            step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 6'b0);
            step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 6'($urandom));
            for (int n = 0; n < 300; n++)
                step($urandom_range(0, 3) != 0, (n == 0) || ($urandom_range(0, 199) == 0),
                     16'($urandom), 16'($urandom), $urandom_range(0, 7) == 0, 6'($urandom));
            for (int n = 0; n < 2*FRAME && busy_m; n++)
                step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 6'b0);
            chk("rand_frame_end", 32'(busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
